clock_set_ctrl: RTL
===================

// Module: clock_set_ctrl
// PURPOSE
//  Time-set controller for the seconds-of-day clock. Button-driven FSM: pauses the clock,
//  decomposes its current time into h/m/s, lets the user edit each field, then reloads
//  the clock by driving its start_time and pulsing its active-low reset.
//  Sits between the debounced front-panel buttons and the clock core's control inputs.
// PARAMETERS
//  FULL_DAY     86400     seconds per day; legal time range 0..FULL_DAY-1
//  BLINK_HALF   25000000  clk cycles per blink half-period (0.5 s at 50 MHz)
//  TIME_W       17        width of all seconds-of-day buses
// PORTS
//  clk          in   1       system clock; all logic on rising edge
//  reset        in   1       synchronous, active-low reset
//  btn_mode     in   1       debounced, active-high level; rising edge = advance mode
//  btn_inc      in   1       debounced, active-high level; rising edge = field +1
//  btn_dec      in   1       debounced, active-high level; rising edge = field -1
//  cur_time     in   TIME_W  clock core's current displayed time (seconds of day)
//  start_time   out  TIME_W  to clock core start_time; registered
//  clk_reset_n  out  1       to clock core reset (active-low); registered
//  clk_pause_n  out  1       to clock core pause (active-low = paused); registered
//  set_mode     out  2       0=RUN 1=hours 2=minutes 3=seconds being edited
//  blink        out  1       display blank strobe for the field being edited
// BEHAVIOUR
//  Reset (reset=0 at edge): state RUN, h/m/s=0, start_time=0, clk_reset_n=0,
//   clk_pause_n=1, set_mode=0, blink=0, edge-detect history=0. clk_reset_n rises to 1 on
//   the first edge with reset=1, so the core sees at least one reset cycle.
//  Buttons: rising edge = level 1 now, 0 previous cycle; one-cycle pulse, one action each.
//  States: RUN -> CAP_H -> CAP_M -> SET_H -> SET_M -> SET_S -> LOAD -> RUN.
//  RUN: clk_pause_n=1. mode edge -> CAP_H next cycle, clk_pause_n=0 the same cycle.
//   Latch t=cur_time on entry; if t>=FULL_DAY, latch 0 instead.
//  CAP_H: while t>=3600 { t-=3600; h++ } one subtraction per cycle (<=23 cycles) -> CAP_M.
//  CAP_M: while t>=60 { t-=60; m++ } per cycle (<=59 cycles); then s=t -> SET_H.
//   Max capture latency from mode edge to SET_H: 84 cycles. All buttons ignored in CAP_*.
//  SET_H/SET_M/SET_S: set_mode=1/2/3. inc: field+1, dec: field-1.
//   Each field wraps within itself and never carries: h 23->0, 0->23; m,s 59->0, 0->59.
//   inc and dec edges in the same cycle: no change. mode edge has priority over inc/dec
//   in the same cycle: advance state, field unchanged. mode in SET_S -> LOAD.
//  LOAD (exactly 1 cycle): start_time <= h*3600+m*60+s (shift-add only, no multipliers),
//   clk_reset_n=0 for this one cycle. Next cycle: RUN, clk_reset_n=1, clk_pause_n=1.
//   The core then shows start_time+0 and counts from there.
//  start_time is changed only in LOAD or by reset; it holds across edits and RUN.
//  blink: 0 in RUN/CAP_*/LOAD. In SET_* a counter runs and toggles blink every BLINK_HALF
//   cycles. Counter cleared and blink=1 on every SET_* entry and on every accepted inc/dec.
//  Reset mid-edit or mid-capture: abandon edit, full reset values. The core is reset
//   via clk_reset_n=0, and start_time=0.
// STRUCTURE
//  clock_pkg: state enum (RUN,CAP_H,CAP_M,SET_H,SET_M,SET_S,LOAD), FULL_DAY,
//   SEC_PER_HOUR=3600, SEC_PER_MIN=60, field maxima 23/59.
//  Sub-module btn_edge (one instance per button): sync-reset register + rising-edge pulse.
//  FSM, capture subtractor, field counters, blink counter and the LOAD adder sit in this
//   module.
// TESTING
//  1 Reset held 3 cycles then released -> set_mode=0, start_time=0, clk_pause_n=1;
//    clk_reset_n=0 during reset, 1 on the first cycle after.
//  2 cur_time=45296, mode edge -> pause_n=0 next cycle; SET_H reached within 84 cycles
//    with h=12, m=34, s=56.
//  3 In SET_H at h=23, inc -> h=0. In SET_M at m=0, dec -> m=59, h unchanged.
//    inc+dec in the same cycle -> no change.
//  4 Edit to 01:02:03, mode x3 -> one LOAD cycle with clk_reset_n=0,
//    start_time=3723, then RUN with pause_n=1.
//  5 cur_time=86400 at mode edge -> captured 00:00:00. Reset asserted in SET_M
//    -> RUN, start_time=0, clk_reset_n=0.
//  6 BLINK_HALF=4: in SET_S blink pattern is 1 for 4 cycles, then 0 for 4 cycles;
//    an inc edge restarts the pattern with blink=1.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants, state encoding and time helper for the clock time-set controller.
package clock_pkg;

  localparam int FULL_DAY     = 86400;
  localparam int TIME_W       = 17;
  localparam int SEC_PER_HOUR = 3600;
  localparam int SEC_PER_MIN  = 60;
  localparam int HOUR_MAX     = 23;
  localparam int MIN_MAX      = 59;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_CAP_H,
    ST_CAP_M,
    ST_SET_H,
    ST_SET_M,
    ST_SET_S,
    ST_LOAD
  } state_e;

  // h*3600 + m*60 + s built from shifts: 3600 = 2048+1024+512+16, 60 = 32+16+8+4.
  function automatic logic [16:0] hms_to_sec(input logic [4:0] h,
                                             input logic [5:0] m,
                                             input logic [5:0] s);
    logic [16:0] hh, mm, ss;
    hh = {12'd0, h};
    mm = {11'd0, m};
    ss = {11'd0, s};
    return (hh << 11) + (hh << 10) + (hh << 9) + (hh << 4)
         + (mm << 5) + (mm << 4) + (mm << 3) + (mm << 2) + ss;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level; one-cycle pulse per press.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!reset) prev_q <= 1'b0;
    else        prev_q <= btn_i;
  end

  assign pulse_o = btn_i & ~prev_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: pauses the clock core, splits its time into h/m/s, edits, reloads.
//  state    | meaning
//  ST_RUN   | clock running, waiting for mode press
//  ST_CAP_H | peel whole hours off captured time, one per cycle
//  ST_CAP_M | peel whole minutes off remainder; remainder becomes seconds
//  ST_SET_H | editing hours
//  ST_SET_M | editing minutes
//  ST_SET_S | editing seconds
//  ST_LOAD  | one cycle: drive start_time, hold core in reset
module clock_set_ctrl #(
  parameter int FULL_DAY   = 86400,
  parameter int BLINK_HALF = 25000000,
  parameter int TIME_W     = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic [TIME_W-1:0] cur_time,
  output logic [TIME_W-1:0] start_time,
  output logic              clk_reset_n,
  output logic              clk_pause_n,
  output logic [1:0]        set_mode,
  output logic              blink
);
  import clock_pkg::*;

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0]     BLINK_RELOAD = BW'(BLINK_HALF - 1);
  localparam logic [TIME_W-1:0] DAY_T        = TIME_W'(FULL_DAY);
  localparam logic [TIME_W-1:0] HOUR_T       = TIME_W'(SEC_PER_HOUR);
  localparam logic [TIME_W-1:0] MIN_T        = TIME_W'(SEC_PER_MIN);
  localparam logic [4:0]        H_MAX        = 5'(HOUR_MAX);
  localparam logic [5:0]        M_MAX        = 6'(MIN_MAX);

  logic mode_p, inc_p, dec_p;

  btn_edge u_mode (.clk(clk), .reset(reset), .btn_i(btn_mode), .pulse_o(mode_p));
  btn_edge u_inc  (.clk(clk), .reset(reset), .btn_i(btn_inc),  .pulse_o(inc_p));
  btn_edge u_dec  (.clk(clk), .reset(reset), .btn_i(btn_dec),  .pulse_o(dec_p));

  state_e             state_q, state_d;
  logic [TIME_W-1:0]  t_q, t_d;
  logic [TIME_W-1:0]  start_q, start_d;
  logic [4:0]         h_q, h_d;
  logic [5:0]         m_q, m_d, s_q, s_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic               blink_q, blink_d;
  logic               rstn_q, pausen_q;
  logic               in_set, step, set_next;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    start_d = start_q;
    h_d     = h_q;
    m_d     = m_q;
    s_d     = s_q;
    blink_d = blink_q;
    bcnt_d  = bcnt_q;

    in_set = (state_q == ST_SET_H) || (state_q == ST_SET_M) || (state_q == ST_SET_S);
    // mode wins over inc/dec; simultaneous inc+dec cancel out
    step   = in_set && !mode_p && (inc_p ^ dec_p);

    case (state_q)
      ST_RUN: if (mode_p) begin
        state_d = ST_CAP_H;
        t_d     = (cur_time >= DAY_T) ? '0 : cur_time;
        h_d     = '0;
        m_d     = '0;
        s_d     = '0;
      end
      ST_CAP_H: if (t_q >= HOUR_T) begin
        t_d = t_q - HOUR_T;
        h_d = h_q + 5'd1;
      end else begin
        state_d = ST_CAP_M;
      end
      ST_CAP_M: if (t_q >= MIN_T) begin
        t_d = t_q - MIN_T;
        m_d = m_q + 6'd1;
      end else begin
        s_d     = t_q[5:0];
        state_d = ST_SET_H;
      end
      ST_SET_H: if (mode_p) state_d = ST_SET_M;
        else if (step) h_d = inc_p ? ((h_q == H_MAX) ? 5'd0 : h_q + 5'd1)
                                   : ((h_q == 5'd0) ? H_MAX : h_q - 5'd1);
      ST_SET_M: if (mode_p) state_d = ST_SET_S;
        else if (step) m_d = inc_p ? ((m_q == M_MAX) ? 6'd0 : m_q + 6'd1)
                                   : ((m_q == 6'd0) ? M_MAX : m_q - 6'd1);
      ST_SET_S: if (mode_p) begin
        state_d = ST_LOAD;
        start_d = TIME_W'(hms_to_sec(h_q, m_q, s_q));
      end else if (step) begin
        s_d = inc_p ? ((s_q == M_MAX) ? 6'd0 : s_q + 6'd1)
                    : ((s_q == 6'd0) ? M_MAX : s_q - 6'd1);
      end
      ST_LOAD: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    set_next = (state_d == ST_SET_H) || (state_d == ST_SET_M) || (state_d == ST_SET_S);
    if (!set_next) begin
      blink_d = 1'b0;
      bcnt_d  = BLINK_RELOAD;
    end else if ((state_d != state_q) || step) begin
      blink_d = 1'b1;
      bcnt_d  = BLINK_RELOAD;
    end else if (bcnt_q == '0) begin
      blink_d = ~blink_q;
      bcnt_d  = BLINK_RELOAD;
    end else begin
      bcnt_d  = bcnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      t_q      <= '0;
      start_q  <= '0;
      h_q      <= '0;
      m_q      <= '0;
      s_q      <= '0;
      blink_q  <= 1'b0;
      bcnt_q   <= BLINK_RELOAD;
      rstn_q   <= 1'b0;
      pausen_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      start_q  <= start_d;
      h_q      <= h_d;
      m_q      <= m_d;
      s_q      <= s_d;
      blink_q  <= blink_d;
      bcnt_q   <= bcnt_d;
      rstn_q   <= (state_d != ST_LOAD);
      pausen_q <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    set_mode = 2'd0;
    case (state_q)
      ST_SET_H: set_mode = 2'd1;
      ST_SET_M: set_mode = 2'd2;
      ST_SET_S: set_mode = 2'd3;
      default:  set_mode = 2'd0;
    endcase
  end

  assign start_time  = start_q;
  assign clk_reset_n = rstn_q;
  assign clk_pause_n = pausen_q;
  assign blink       = blink_q;

endmodule
